// File: rtl/rgb_seq_pkg.sv
// Shared types and helpers for the RGB hue sequencer: phase encoding,
// duty triple, phase successor and the (phase, level) -> duty mapping.
package rgb_seq_pkg;

    localparam int NUM_PHASES = 6;

    // Each phase is named after the one channel that ramps during it.
    typedef enum logic [2:0] {
        PH_G_UP = 3'd0,
        PH_R_DN = 3'd1,
        PH_B_UP = 3'd2,
        PH_G_DN = 3'd3,
        PH_R_UP = 3'd4,
        PH_B_DN = 3'd5
    } phase_e;

    typedef struct packed {
        int unsigned r;
        int unsigned g;
        int unsigned b;
    } rgb_t;

    function automatic phase_e next_phase(input phase_e ph);
        return (int'(ph) == NUM_PHASES - 1) ? PH_G_UP : phase_e'(ph + 3'd1);
    endfunction

    function automatic rgb_t duty_calc(input phase_e      ph,
                                       input int unsigned level,
                                       input int unsigned inc,
                                       input int unsigned full);
        int unsigned up;
        int unsigned dn;
        rgb_t        d;
        up = level * inc;
        dn = full - up;
        d  = '0;
        case (ph)
            PH_G_UP: begin d.r = full; d.g = up;   end
            PH_R_DN: begin d.r = dn;   d.g = full; end
            PH_B_UP: begin d.g = full; d.b = up;   end
            PH_G_DN: begin d.g = dn;   d.b = full; end
            PH_R_UP: begin d.r = up;   d.b = full; end
            PH_B_DN: begin d.r = full; d.b = dn;   end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rgb_hue_sequencer_step_prescaler.sv
// Step pulse generator: free-running prescaler while running, manual
// single-step requests while held.
module step_prescaler #(
    parameter int STEP_INTERVAL = 6000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic step_req,
    output logic step
);

    localparam int PW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;

    logic [PW-1:0] count;
    logic          at_wrap;

    assign at_wrap = (count == PW'(STEP_INTERVAL - 1));

    // While running, step_req is deliberately ignored so a request that
    // lands on the wrap cycle cannot produce a second step.
    always_comb begin
        step = run ? at_wrap : step_req;
    end

    // NOTE: sequential state is written with <= only, so every block
    // clocked on the same edge sees pre-edge values of each other's state.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (run) begin
            count <= at_wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/rgb_hue_sequencer.sv
// Three-channel hue wheel sequencer (R->Y->G->C->B->M->R) with duty values
// double-buffered and committed on the last cycle of each PWM frame.
module rgb_hue_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int PWM_INTERVAL    = 1200,
    parameter int STEP_INTERVAL   = 6000,
    parameter int STEPS_PER_PHASE = 300
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            run,
    input  logic                            step_req,
    output logic [$clog2(PWM_INTERVAL)-1:0] pwm_value_r,
    output logic [$clog2(PWM_INTERVAL)-1:0] pwm_value_g,
    output logic [$clog2(PWM_INTERVAL)-1:0] pwm_value_b,
    output logic [2:0]                      phase,
    output logic                            step_tick,
    output logic                            frame_start
);

    localparam int          W   = $clog2(PWM_INTERVAL);
    localparam int          LW  = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;
    localparam int unsigned INC = PWM_INTERVAL / STEPS_PER_PHASE;

    if ((PWM_INTERVAL & (PWM_INTERVAL - 1)) == 0) begin : g_bad_pwm_pow2
        $error("PWM_INTERVAL must not be a power of two");
    end
    if ((PWM_INTERVAL % STEPS_PER_PHASE) != 0) begin : g_bad_pwm_div
        $error("PWM_INTERVAL must be divisible by STEPS_PER_PHASE");
    end

    logic [W-1:0]  frame_cnt;
    logic [LW-1:0] level;
    phase_e        phase_q;
    logic          step;
    logic          frame_last;
    rgb_t          shadow;

    step_prescaler #(
        .STEP_INTERVAL(STEP_INTERVAL)
    ) u_step_prescaler (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .step_req(step_req),
        .step    (step)
    );

    assign frame_last  = (frame_cnt == W'(PWM_INTERVAL - 1));
    assign frame_start = (frame_cnt == '0);
    assign phase       = phase_q;
    assign shadow      = duty_calc(phase_q, 32'(level), INC, PWM_INTERVAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level     <= '0;
            phase_q   <= PH_G_UP;
            step_tick <= 1'b0;
        end else begin
            step_tick <= step;
            if (step) begin
                if (level == LW'(STEPS_PER_PHASE - 1)) begin
                    level   <= '0;
                    phase_q <= next_phase(phase_q);
                end else begin
                    level <= level + 1'b1;
                end
            end
        end
    end

    // A step on the commit cycle is not seen here until the next frame,
    // because shadow is derived from the pre-edge level/phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_value_r <= W'(PWM_INTERVAL);
            pwm_value_g <= '0;
            pwm_value_b <= '0;
        end else if (frame_last) begin
            pwm_value_r <= W'(shadow.r);
            pwm_value_g <= W'(shadow.g);
            pwm_value_b <= W'(shadow.b);
        end
    end

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Self-checking bench: per-cycle comparison against a hue-wheel model,
// a table of step-count checkpoints and hand-written corner sequences.
module tb_rgb_hue_sequencer;

    localparam int FULL   = 12;
    localparam int SI     = 5;
    localparam int SPP    = 3;
    localparam int NSTEPS = 6 * SPP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       step_req = 1'b0;
    logic [3:0] pwm_value_r, pwm_value_g, pwm_value_b;
    logic [2:0] phase;
    logic       step_tick, frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    // Colour at the start of each phase; duty within a phase interpolates linearly.
    int col [6][3] = '{'{12, 0, 0}, '{12, 12, 0}, '{0, 12, 0},
                       '{0, 12, 12}, '{0, 0, 12}, '{12, 0, 12}};

    int m_steps, m_presc, m_frame, m_tick;
    int m_out [3];

    typedef struct {
        int n_steps;
        int ph;
        int r;
        int g;
        int b;
    } vec_t;
    vec_t vecs [12];

    rgb_hue_sequencer #(
        .PWM_INTERVAL(FULL),
        .STEP_INTERVAL(SI),
        .STEPS_PER_PHASE(SPP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .step_req(step_req),
        .pwm_value_r(pwm_value_r),
        .pwm_value_g(pwm_value_g),
        .pwm_value_b(pwm_value_b),
        .phase(phase),
        .step_tick(step_tick),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int hue(input int s, input int ch);
        int p, l, a, e;
        p = (s / SPP) % 6;
        l = s % SPP;
        a = col[p][ch];
        e = col[(p + 1) % 6][ch];
        return a + (e - a) * l / SPP;
    endfunction

    task automatic model_step();
        int stp;
        if (rst) begin
            m_steps = 0; m_presc = 0; m_frame = 0; m_tick = 0;
            m_out[0] = FULL; m_out[1] = 0; m_out[2] = 0;
        end else begin
            stp = run ? int'(m_presc == SI - 1) : int'(step_req);
            if (m_frame == FULL - 1)
                for (int c = 0; c < 3; c++) m_out[c] = hue(m_steps, c);
            m_tick  = stp;
            m_frame = (m_frame + 1) % FULL;
            if (run) m_presc = (m_presc + 1) % SI;
            if (stp != 0) m_steps = (m_steps + 1) % NSTEPS;
        end
    endtask

    task automatic compare_model();
        check("r", 32'(pwm_value_r), m_out[0]);
        check("g", 32'(pwm_value_g), m_out[1]);
        check("b", 32'(pwm_value_b), m_out[2]);
        check("phase", 32'(phase), m_steps / SPP);
        check("step_tick", 32'(step_tick), m_tick);
        check("frame_start", 32'(frame_start), int'(m_frame == 0));
    endtask

    // Inputs are set at the falling edge; outputs are checked at the next one.
    task automatic clk_cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step_req = 1'b0;
        clk_cycle();
        clk_cycle();
        rst = 1'b0;
    endtask

    task automatic pulse_step(output int ticks);
        step_req = 1'b1;
        clk_cycle();
        ticks = int'(step_tick);
        step_req = 1'b0;
        clk_cycle();
    endtask

    initial begin
        int cnt, fs, t, prev, bound;
        int seq[$];

        vecs[0]  = '{1, 0, 12, 4, 0};
        vecs[1]  = '{1, 0, 12, 8, 0};
        vecs[2]  = '{1, 1, 12, 12, 0};
        vecs[3]  = '{2, 1, 4, 12, 0};
        vecs[4]  = '{1, 2, 0, 12, 0};
        vecs[5]  = '{3, 3, 0, 12, 12};
        vecs[6]  = '{1, 3, 0, 8, 12};
        vecs[7]  = '{2, 4, 0, 0, 12};
        vecs[8]  = '{2, 4, 8, 0, 12};
        vecs[9]  = '{1, 5, 12, 0, 12};
        vecs[10] = '{2, 5, 12, 0, 4};
        vecs[11] = '{1, 0, 12, 0, 0};

        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_frame_start", 32'(frame_start), 1);
        check("rst_r", 32'(pwm_value_r), FULL);
        check("rst_g", 32'(pwm_value_g), 0);
        check("rst_b", 32'(pwm_value_b), 0);
        check("rst_phase", 32'(phase), 0);
        check("rst_step_tick", 32'(step_tick), 0);

        // Running: 18 steps in 90 cycles, phase walks the whole wheel
        run = 1'b1;
        cnt = 0; prev = 0;
        repeat (NSTEPS * SI) begin
            clk_cycle();
            cnt += int'(step_tick);
            if (int'(phase) != prev) begin
                seq.push_back(int'(phase));
                prev = int'(phase);
            end
        end
        check("run_tick_count", cnt, NSTEPS);
        check("run_phase_changes", seq.size(), 6);
        for (int i = 0; i < 6 && i < seq.size(); i++)
            check("run_phase_seq", seq[i], (i + 1) % 6);
        repeat (30) clk_cycle();

        // Table of single-step checkpoints around the wheel
        do_reset();
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n_steps; k++) begin
                pulse_step(t);
                check("vec_step_tick", t, 1);
            end
            repeat (FULL + 1) clk_cycle();
            check("vec_phase", 32'(phase), vecs[i].ph);
            check("vec_r", 32'(pwm_value_r), vecs[i].r);
            check("vec_g", 32'(pwm_value_g), vecs[i].g);
            check("vec_b", 32'(pwm_value_b), vecs[i].b);
        end

        // Hold: no steps, frame_start keeps pulsing
        do_reset();
        cnt = 0; fs = 0;
        for (int i = 0; i < 100; i++) begin
            clk_cycle();
            cnt += int'(step_tick);
            if (i < 96) fs += int'(frame_start);
        end
        check("hold_ticks", cnt, 0);
        check("hold_frame_starts", fs, 8);
        check("hold_g", 32'(pwm_value_g), 0);
        pulse_step(t);
        cnt = t;
        repeat (FULL + 1) begin
            clk_cycle();
            cnt += int'(step_tick);
        end
        check("hold_single_tick", cnt, 1);
        check("hold_g_after_step", 32'(pwm_value_g), 4);

        // Collision: step_req held across a prescaler wrap gives one step
        do_reset();
        run = 1'b1; step_req = 1'b1;
        cnt = 0;
        repeat (SI) begin
            clk_cycle();
            cnt += int'(step_tick);
        end
        check("collision_ticks", cnt, 1);
        step_req = 1'b0; run = 1'b0;
        repeat (FULL + 1) clk_cycle();
        check("collision_g", 32'(pwm_value_g), 4);

        // Commit boundary: step on the last frame cycle lands one frame later
        do_reset();
        bound = 0;
        while (m_frame != FULL - 1 && bound < 2 * FULL) begin
            clk_cycle();
            bound++;
        end
        check("boundary_reached", int'(m_frame == FULL - 1), 1);
        step_req = 1'b1;
        clk_cycle();
        step_req = 1'b0;
        check("boundary_frame_start", 32'(frame_start), 1);
        check("boundary_g_unchanged", 32'(pwm_value_g), 0);
        repeat (FULL) clk_cycle();
        check("boundary_frame_start2", 32'(frame_start), 1);
        check("boundary_g_new", 32'(pwm_value_g), 4);

        // Reset at phase 4, level 2, right after a step
        do_reset();
        for (int k = 0; k < 4 * SPP + 1; k++) pulse_step(t);
        step_req = 1'b1;
        clk_cycle();
        step_req = 1'b0;
        check("midphase_phase", 32'(phase), 4);
        check("midphase_tick", 32'(step_tick), 1);
        rst = 1'b1;
        clk_cycle();
        rst = 1'b0;
        check("midrst_phase", 32'(phase), 0);
        check("midrst_r", 32'(pwm_value_r), FULL);
        check("midrst_g", 32'(pwm_value_g), 0);
        check("midrst_b", 32'(pwm_value_b), 0);
        check("midrst_tick", 32'(step_tick), 0);

        // Randomised run/hold/step/reset traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ((i % 40) == 0) run = ($urandom_range(0, 2) != 0);
            step_req = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            clk_cycle();
        end
        rst = 1'b0; run = 1'b0; step_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
